// File: rtl/data_receiver_pkg.sv
// Shared types and constants for the serial link receiver.
package data_receiver_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_GAP,
        RX_WAIT
    } rx_state_t;

    localparam int RECEIVER_TIMEOUT = 4096;
    localparam int BYTE_BITS        = 8;

endpackage

// File: rtl/data_receiver_link_sync.sv
// N-stage synchronizer with registered level/rise/fall, all three aligned.
module link_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++)
                chain[i] <= chain[i-1];
            level <= chain[STAGES-1];
            rise  <= chain[STAGES-1] & ~level;
            fall  <= ~chain[STAGES-1] & level;
        end
    end

endmodule

// File: rtl/data_receiver.sv
// Serial link receiver: synchronizes the three link wires, assembles
// BYTES bytes LSB-first into one word, flags framing errors and stalls.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int BYTES       = 8,
    parameter int TIMEOUT     = RECEIVER_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_transmission,
    input  logic               in_clock,
    input  logic               in_data,
    output logic [8*BYTES-1:0] data,
    output logic               valid,
    output logic               busy,
    output logic               error
);

    localparam int IW = $clog2(BYTES) + 1;
    localparam int GW = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST = IW'(BYTES - 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT - 1);

    logic tr_lvl, tr_rise, tr_fall;
    logic ck_lvl, ck_rise, ck_fall;
    logic dt_lvl, dt_rise, dt_fall;
    logic unused_edges;

    link_sync #(.STAGES(SYNC_STAGES)) u_sync_tr (
        .clk(clk), .rst(rst), .din(in_transmission),
        .level(tr_lvl), .rise(tr_rise), .fall(tr_fall)
    );
    link_sync #(.STAGES(SYNC_STAGES)) u_sync_ck (
        .clk(clk), .rst(rst), .din(in_clock),
        .level(ck_lvl), .rise(ck_rise), .fall(ck_fall)
    );
    link_sync #(.STAGES(SYNC_STAGES)) u_sync_dt (
        .clk(clk), .rst(rst), .din(in_data),
        .level(dt_lvl), .rise(dt_rise), .fall(dt_fall)
    );

    assign unused_edges = &{1'b0, tr_rise, tr_fall, ck_lvl,
                            ck_fall, dt_rise, dt_fall};

    rx_state_t state, state_n;
    logic [3:0]         bit_cnt, bit_n;
    logic [IW-1:0]      idx, idx_n;
    logic [GW-1:0]      gap_cnt, gap_n;
    logic [7:0]         shreg;
    logic [8*BYTES-1:0] buffer;
    logic               blocked;
    logic               sample, shift_en, store, valid_n, error_n;

    assign sample = ck_rise & tr_lvl;
    assign busy   = (state != RX_IDLE) | valid | error;

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt;
        idx_n    = idx;
        gap_n    = gap_cnt;
        shift_en = 1'b0;
        store    = 1'b0;
        valid_n  = 1'b0;
        error_n  = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (sample && !blocked) begin
                    state_n  = RX_RECV;
                    bit_n    = 4'd1;
                    idx_n    = '0;
                    shift_en = 1'b1;
                end
            end
            RX_RECV: begin
                if (!tr_lvl) begin
                    error_n = 1'b1;
                    state_n = RX_IDLE;
                end else if (sample) begin
                    shift_en = 1'b1;
                    bit_n    = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        store   = 1'b1;
                        state_n = RX_GAP;
                    end
                end
            end
            RX_GAP: begin
                if (sample) begin
                    error_n = 1'b1;
                    state_n = RX_IDLE;
                end else if (!tr_lvl) begin
                    if (idx == LAST) begin
                        valid_n = 1'b1;
                        state_n = RX_IDLE;
                    end else begin
                        idx_n   = idx + IW'(1);
                        gap_n   = '0;
                        state_n = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                if (sample) begin
                    state_n  = RX_RECV;
                    bit_n    = 4'd1;
                    shift_en = 1'b1;
                end else if (gap_cnt == GAP_MAX) begin
                    error_n = 1'b1;
                    state_n = RX_IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = RX_IDLE;
        endcase
        // Leaving a word always starts the next one from clean counters
        if (state_n == RX_IDLE) begin
            bit_n = '0;
            idx_n = '0;
            gap_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            buffer  <= '0;
            data    <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
            blocked <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            idx     <= idx_n;
            gap_cnt <= gap_n;
            valid   <= valid_n;
            error   <= error_n;
            if (shift_en)
                shreg <= {dt_lvl, shreg[7:1]};
            if (store)
                buffer[8*int'(idx) +: 8] <= {dt_lvl, shreg[7:1]};
            if (valid_n)
                data <= buffer;
            // After an error, ignore the link until the frame line drops
            if (error_n)
                blocked <= 1'b1;
            else if (!tr_lvl)
                blocked <= 1'b0;
        end
    end

endmodule
